// File: rtl/lane_reorder_mapper_if.sv
// rtl/lane_reorder_mapper_if.sv - control, ID and data bundle for the lane reorder mapper
interface lane_reorder_mapper_if #(
  parameter int N_LANES = 20,
  parameter int NB_ID   = $clog2(N_LANES),
  parameter int NB_DATA = 66
);
  localparam int NB_ID_BUS   = N_LANES * NB_ID;
  localparam int NB_DATA_BUS = N_LANES * NB_DATA;

  logic                   i_enable;
  logic                   i_valid;
  logic                   i_deskew_done;
  logic                   i_reorder_restart;
  logic [NB_ID_BUS-1:0]   i_id;
  logic [NB_DATA_BUS-1:0] i_data;
  logic [NB_DATA_BUS-1:0] o_data;
  logic                   o_valid;
  logic                   o_reorder_done;
  logic                   o_reorder_error;
  logic [NB_ID_BUS-1:0]   o_mux_selector;

  modport master (
    output i_enable, i_valid, i_deskew_done, i_reorder_restart, i_id, i_data,
    input  o_data, o_valid, o_reorder_done, o_reorder_error, o_mux_selector
  );

  modport slave (
    input  i_enable, i_valid, i_deskew_done, i_reorder_restart, i_id, i_data,
    output o_data, o_valid, o_reorder_done, o_reorder_error, o_mux_selector
  );
endinterface

// File: rtl/lane_reorder_mapper.sv
// rtl/lane_reorder_mapper.sv - builds the logical-to-physical lane map from PCS lane IDs and reorders data
module lane_reorder_mapper #(
  parameter int N_LANES     = 20,
  parameter int NB_ID       = $clog2(N_LANES),
  parameter int NB_DATA     = 66,
  parameter int NB_ID_BUS   = N_LANES * NB_ID,
  parameter int NB_DATA_BUS = N_LANES * NB_DATA
) (
  input logic                  i_clock,
  input logic                  i_reset,
  lane_reorder_mapper_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUILD, DONE, ERROR} state_t;

  state_t                 state;
  state_t                 next_state;
  logic [NB_ID-1:0]       counter;
  logic [NB_ID-1:0]       id_snap [N_LANES];
  logic [NB_ID-1:0]       sel     [N_LANES];
  logic [N_LANES-1:0]     seen;
  logic                   err_flag;
  logic [NB_ID-1:0]       cur_id;
  logic                   cur_bad;
  logic                   last_lane;
  logic                   clear;
  logic [NB_DATA-1:0]     din     [N_LANES];
  logic [NB_DATA_BUS-1:0] data_q;
  logic                   valid_q;
  logic                   done_q;
  logic                   error_q;
  logic [NB_ID_BUS-1:0]   sel_bus;

  assign clear = i_reset || bus.i_reorder_restart;

  // Current lane's ID is bad when out of range or already claimed by an earlier lane
  always_comb begin
    cur_id    = id_snap[counter];
    last_lane = (counter == NB_ID'(N_LANES - 1));
    cur_bad   = ({1'b0, cur_id} >= (NB_ID + 1)'(N_LANES));
    for (int p = 0; p < N_LANES; p++) begin
      if (seen[p] && (cur_id == NB_ID'(p))) cur_bad = 1'b1;
    end
  end

  // Next-state decode; everything waits on the clock enable
  always_comb begin
    next_state = state;
    if (bus.i_enable) begin
      case (state)
        IDLE:    if (bus.i_deskew_done) next_state = BUILD;
        BUILD: begin
          if (!bus.i_deskew_done)  next_state = IDLE;
          else if (last_lane)      next_state = (err_flag || cur_bad) ? ERROR : DONE;
        end
        DONE:    if (!bus.i_deskew_done) next_state = IDLE;
        ERROR:   if (!bus.i_deskew_done) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // State, lane counter, seen mask, error flag and selector table
  always_ff @(posedge i_clock) begin
    if (clear) begin
      state    <= IDLE;
      counter  <= '0;
      seen     <= '0;
      err_flag <= 1'b0;
      for (int p = 0; p < N_LANES; p++) sel[p] <= NB_ID'(p);
    end else if (bus.i_enable) begin
      state <= next_state;
      if (state == BUILD && bus.i_deskew_done) begin
        if (cur_bad) begin
          err_flag <= 1'b1;
        end else begin
          for (int p = 0; p < N_LANES; p++) begin
            if (cur_id == NB_ID'(p)) begin
              sel[p]  <= counter;
              seen[p] <= 1'b1;
            end
          end
        end
        if (!last_lane) counter <= counter + 1'b1;
      end else if (state == IDLE && bus.i_deskew_done) begin
        seen    <= '0;
        counter <= '0;
      end else if (state != IDLE && !bus.i_deskew_done) begin
        // Losing deskew discards the partial or finished map
        seen     <= '0;
        counter  <= '0;
        err_flag <= 1'b0;
        for (int p = 0; p < N_LANES; p++) sel[p] <= NB_ID'(p);
      end
    end
  end

  // Snapshot of the received IDs taken once when the build starts
  always_ff @(posedge i_clock) begin
    if (!clear && bus.i_enable && state == IDLE && bus.i_deskew_done) begin
      for (int k = 0; k < N_LANES; k++) id_snap[k] <= bus.i_id[NB_ID_BUS-1-k*NB_ID -: NB_ID];
    end
  end

  // Status flags decoded from the upcoming state so they line up with the state change
  always_ff @(posedge i_clock) begin
    if (clear) begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q  <= (next_state == DONE);
      error_q <= (next_state == ERROR);
    end
  end

  // Split the deskewed bus into per-lane blocks and pack the selector table
  always_comb begin
    for (int k = 0; k < N_LANES; k++) din[k] = bus.i_data[NB_DATA_BUS-1-k*NB_DATA -: NB_DATA];
    sel_bus = '0;
    for (int p = 0; p < N_LANES; p++) sel_bus[NB_ID_BUS-1-p*NB_ID -: NB_ID] = sel[p];
  end

  // Registered crossbar: logical lane p takes physical lane sel[p] while the map is valid
  always_ff @(posedge i_clock) begin
    if (clear) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (!bus.i_enable) begin
      valid_q <= 1'b0;
    end else if (state == DONE) begin
      for (int p = 0; p < N_LANES; p++) data_q[NB_DATA_BUS-1-p*NB_DATA -: NB_DATA] <= din[sel[p]];
      valid_q <= bus.i_valid;
    end else begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end
  end

  assign bus.o_data          = data_q;
  assign bus.o_valid         = valid_q;
  assign bus.o_reorder_done  = done_q;
  assign bus.o_reorder_error = error_q;
  assign bus.o_mux_selector  = sel_bus;

endmodule

// File: tb/tb_lane_reorder_mapper.sv
// tb/tb_lane_reorder_mapper.sv - scoreboard bench for the lane reorder mapper
module tb_lane_reorder_mapper;
  localparam int N_LANES     = 20;
  localparam int NB_ID       = $clog2(N_LANES);
  localparam int NB_DATA     = 66;
  localparam int NB_ID_BUS   = N_LANES * NB_ID;
  localparam int NB_DATA_BUS = N_LANES * NB_DATA;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;

  always #5 i_clock = ~i_clock;

  lane_reorder_mapper_if #(.N_LANES(N_LANES), .NB_ID(NB_ID), .NB_DATA(NB_DATA)) bus ();

  lane_reorder_mapper #(
    .N_LANES(N_LANES), .NB_ID(NB_ID), .NB_DATA(NB_DATA),
    .NB_ID_BUS(NB_ID_BUS), .NB_DATA_BUS(NB_DATA_BUS)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .bus(bus)
  );

  typedef struct {
    bit                     valid;
    logic [NB_DATA_BUS-1:0] data;
  } exp_t;

  exp_t             sb [$];
  int               total = 0;
  int               bad   = 0;
  logic [NB_ID-1:0] ids     [N_LANES];
  logic [NB_ID-1:0] exp_sel [N_LANES];
  bit               exp_err;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic set_identity_sel();
    for (int p = 0; p < N_LANES; p++) exp_sel[p] = NB_ID'(p);
  endtask

  // Reference mapping: first lane to claim an ID wins, bad IDs only raise the error
  task automatic build_model();
    bit seen [N_LANES];
    exp_err = 1'b0;
    for (int p = 0; p < N_LANES; p++) begin
      exp_sel[p] = NB_ID'(p);
      seen[p]    = 1'b0;
    end
    for (int k = 0; k < N_LANES; k++) begin
      int id;
      id = int'(ids[k]);
      if (id >= N_LANES || seen[id]) exp_err = 1'b1;
      else begin
        exp_sel[id] = NB_ID'(k);
        seen[id]    = 1'b1;
      end
    end
  endtask

  function automatic logic [NB_ID_BUS-1:0] pack_sel();
    logic [NB_ID_BUS-1:0] v;
    v = '0;
    for (int p = 0; p < N_LANES; p++) v[NB_ID_BUS-1-p*NB_ID -: NB_ID] = exp_sel[p];
    return v;
  endfunction

  task automatic check_sel(input string tag);
    check(tag, 128'(bus.o_mux_selector), 128'(pack_sel()));
  endtask

  task automatic load_ids();
    for (int k = 0; k < N_LANES; k++) bus.i_id[NB_ID_BUS-1-k*NB_ID -: NB_ID] = ids[k];
  endtask

  // Raise deskew from IDLE and run the N_LANES enabled build cycles
  task automatic run_build(input bit gaps);
    int en_cnt;
    int guard;
    build_model();
    load_ids();
    bus.i_deskew_done = 1'b1;
    bus.i_enable      = 1'b1;
    bus.i_valid       = 1'b1;
    step();
    en_cnt = 0;
    guard  = 0;
    while (en_cnt < N_LANES && guard < 200) begin
      logic en;
      en = !gaps || (guard % 2 == 0);
      bus.i_enable = en;
      step();
      guard++;
      if (en) en_cnt++;
      if (!en) check("gap_valid", 128'(bus.o_valid), 128'(0));
      if (en_cnt < N_LANES) check("done_early", 128'(bus.o_reorder_done), 128'(0));
    end
    check("build_cycles", 128'(en_cnt), 128'(N_LANES));
    bus.i_enable = 1'b1;
    check("done", 128'(bus.o_reorder_done), 128'(!exp_err));
    check("error", 128'(bus.o_reorder_error), 128'(exp_err));
    check("build_valid", 128'(bus.o_valid), 128'(0));
    check_sel("selector");
  endtask

  // Drive data in DONE, push the expected reorder, pop and compare one cycle later
  task automatic stream(input int n, input int base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      logic en;
      logic v;
      en = !gaps || (i % 3 != 1);
      v  = (i % 4 != 2);
      bus.i_enable = en;
      bus.i_valid  = v;
      for (int k = 0; k < N_LANES; k++)
        bus.i_data[NB_DATA_BUS-1-k*NB_DATA -: NB_DATA] = NB_DATA'(base + k + (i << 12));
      e.valid = en && v;
      e.data  = '0;
      for (int p = 0; p < N_LANES; p++)
        e.data[NB_DATA_BUS-1-p*NB_DATA -: NB_DATA] = NB_DATA'(base + int'(exp_sel[p]) + (i << 12));
      sb.push_back(e);
      step();
      if (sb.size() == 0) check("sb_underflow", 128'(1), 128'(0));
      else begin
        e = sb.pop_front();
        check("o_valid", 128'(bus.o_valid), 128'(e.valid));
        check("done_hold", 128'(bus.o_reorder_done), 128'(1));
        if (e.valid) begin
          for (int p = 0; p < N_LANES; p++)
            check($sformatf("data_p%0d", p), 128'(bus.o_data[NB_DATA_BUS-1-p*NB_DATA -: NB_DATA]),
                  128'(e.data[NB_DATA_BUS-1-p*NB_DATA -: NB_DATA]));
        end
      end
    end
    bus.i_enable = 1'b1;
    bus.i_valid  = 1'b0;
  endtask

  task automatic drop_deskew(input string tag);
    bus.i_deskew_done = 1'b0;
    step();
    set_identity_sel();
    check({tag, "_done"}, 128'(bus.o_reorder_done), 128'(0));
    check({tag, "_error"}, 128'(bus.o_reorder_error), 128'(0));
    check_sel({tag, "_sel"});
  endtask

  initial begin
    bus.i_enable          = 1'b0;
    bus.i_valid           = 1'b0;
    bus.i_deskew_done     = 1'b0;
    bus.i_reorder_restart = 1'b0;
    bus.i_id              = '0;
    bus.i_data            = '0;

    // Reset values
    i_reset = 1'b1;
    step();
    step();
    set_identity_sel();
    check("rst_valid", 128'(bus.o_valid), 128'(0));
    check("rst_done", 128'(bus.o_reorder_done), 128'(0));
    check("rst_error", 128'(bus.o_reorder_error), 128'(0));
    check("rst_data", 128'(|bus.o_data), 128'(0));
    check_sel("rst_sel");
    i_reset      = 1'b0;
    bus.i_enable = 1'b1;
    step();

    // Identity IDs
    for (int k = 0; k < N_LANES; k++) ids[k] = NB_ID'(k);
    run_build(1'b0);
    stream(8, 0, 1'b0);
    drop_deskew("drop_ident");

    // Reversed IDs
    for (int k = 0; k < N_LANES; k++) ids[k] = NB_ID'(N_LANES - 1 - k);
    run_build(1'b0);
    stream(8, 'hA00, 1'b0);
    drop_deskew("drop_rev");

    // Duplicate ID 5 on lanes 3 and 7, then restart and rebuild
    for (int k = 0; k < N_LANES; k++) ids[k] = NB_ID'(k);
    ids[3] = NB_ID'(5);
    ids[7] = NB_ID'(5);
    run_build(1'b0);
    bus.i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("dup_hold_error", 128'(bus.o_reorder_error), 128'(1));
      check("dup_valid", 128'(bus.o_valid), 128'(0));
    end
    for (int k = 0; k < N_LANES; k++) ids[k] = NB_ID'(k);
    bus.i_reorder_restart = 1'b1;
    bus.i_enable          = 1'b0;
    step();
    bus.i_reorder_restart = 1'b0;
    bus.i_enable          = 1'b1;
    set_identity_sel();
    check("restart_error", 128'(bus.o_reorder_error), 128'(0));
    check("restart_done", 128'(bus.o_reorder_done), 128'(0));
    check_sel("restart_sel");
    run_build(1'b0);
    stream(4, 'h300, 1'b0);
    drop_deskew("drop_dup");

    // Out-of-range ID on lane 12
    for (int k = 0; k < N_LANES; k++) ids[k] = NB_ID'(k);
    ids[12] = NB_ID'(25);
    run_build(1'b0);
    drop_deskew("drop_oor");

    // Enable gaps with a shuffled ID set
    for (int k = 0; k < N_LANES; k++) ids[k] = NB_ID'(k);
    for (int k = N_LANES - 1; k > 0; k--) begin
      int j;
      logic [NB_ID-1:0] t;
      j      = int'($urandom_range(0, k));
      t      = ids[k];
      ids[k] = ids[j];
      ids[j] = t;
    end
    run_build(1'b1);
    stream(10, 'h5000, 1'b1);
    drop_deskew("drop_gap");

    // Deskew lost mid-build at counter 8
    for (int k = 0; k < N_LANES; k++) ids[k] = NB_ID'(N_LANES - 1 - k);
    load_ids();
    bus.i_deskew_done = 1'b1;
    step();
    for (int i = 0; i < 8; i++) step();
    drop_deskew("drop_mid");

    // Rebuild, lose deskew in DONE, rebuild, then reset in DONE
    run_build(1'b0);
    stream(3, 'h77, 1'b0);
    drop_deskew("drop_done");
    run_build(1'b0);
    stream(2, 'h1234, 1'b0);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    set_identity_sel();
    check("rst2_valid", 128'(bus.o_valid), 128'(0));
    check("rst2_done", 128'(bus.o_reorder_done), 128'(0));
    check("rst2_error", 128'(bus.o_reorder_error), 128'(0));
    check("rst2_data", 128'(|bus.o_data), 128'(0));
    check_sel("rst2_sel");

    check("sb_left", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lane_reorder_mapper.md
Name: lane_reorder_mapper

Overview:
Successor to the PCS RX lane reorder stage. After deskew completes, it captures the per-lane PCS lane IDs and builds the logical-to-physical mux selector, one lane per cycle. It validates the ID set for duplicates and out-of-range values, reporting done or error. It then applies the reorder to the deskewed data bus through a registered crossbar, and sits between the deskew block and the alignment-marker removal / descrambler path.

Parameters:
N_LANES, 20, number of PCS lanes (≥2)
NB_ID, $clog2(N_LANES), bits per lane ID / selector entry
NB_DATA, 66, bits per lane data block
NB_ID_BUS, N_LANES*NB_ID, width of ID and selector buses
NB_DATA_BUS, N_LANES*NB_DATA, width of data buses

Ports:
i_clock  in  1  single clock for the block
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  clock enable; low freezes FSM, counter and selector
i_valid  in  1  i_data valid qualifier
i_deskew_done  in  1  deskew locked; level signal
i_reorder_restart  in  1  synchronous one-cycle request to discard the mapping and rebuild
i_id  in  NB_ID_BUS  ID received on physical lane k at bits [NB_ID_BUS-1-k*NB_ID -: NB_ID] (lane 0 in the MSB chunk)
i_data  in  NB_DATA_BUS  deskewed data, physical lane k at the MSB-first chunk k
o_data  out  NB_DATA_BUS  reordered data, logical lane p at the MSB-first chunk p
o_valid  out  1  o_data qualifier
o_reorder_done  out  1  mapping valid and data path active
o_reorder_error  out  1  invalid ID set detected
o_mux_selector  out  NB_ID_BUS  entry p = physical lane carrying logical lane p

Behaviour:
- Reset (i_reset=1):
  - state=IDLE, counter=0, seen mask=0, error flag=0.
  - Selector = identity (entry p = p).
  - o_data=0, o_valid=0, o_reorder_done=0, o_reorder_error=0.
- i_reorder_restart=1 (with i_reset=0):
  - Same clears as reset, in the same cycle, regardless of state or i_enable.
  - i_reset has priority over restart.
- i_enable=0:
  - No state, counter, seen or selector update.
  - o_valid<=0; o_data holds.
- FSM states: IDLE, BUILD, DONE, ERROR. All transitions below require i_enable=1.
  - IDLE: on i_deskew_done=1, snapshot i_id into an internal register, clear the seen mask, set counter=0, go to BUILD. i_id is not used after the snapshot.
  - BUILD: each cycle, id = snapshot chunk[counter].
    - If id ≥ N_LANES or seen[id]=1, set the error flag; no selector write.
    - Otherwise selector[id] <= counter and seen[id] <= 1.
    - counter++.
    - On the cycle processing counter = N_LANES-1: go to ERROR if the error flag is set (including the current lane); otherwise go to DONE.
    - BUILD lasts exactly N_LANES enabled cycles. With no duplicates and all IDs in range, every ID is guaranteed present, so no separate missing-ID check exists.
  - BUILD with i_deskew_done=0: abort to IDLE; selector returns to identity and the error flag clears.
  - DONE: o_reorder_done=1 and the selector is frozen. i_deskew_done=0 → IDLE, done clears next cycle, selector returns to identity.
  - ERROR: o_reorder_error=1. Exit to IDLE on i_deskew_done=0 or restart. There is no automatic retry while deskew_done stays high.
- Data path: 1-cycle latency, registered.
  - In DONE with i_enable=1: o_data chunk p <= i_data chunk selector[p], and o_valid <= i_valid.
  - In all other states: o_valid<=0, o_data<=0.
  - In the first DONE cycle, o_valid follows that cycle's i_valid at the next edge.
- Outputs o_reorder_done and o_reorder_error are registered (state-decoded flops) and are never high together.
- o_mux_selector is the selector register, continuously driven.
- Counter width is NB_ID. It never wraps, because the exit condition is at N_LANES-1.

Test Plan:
- Identity IDs (lane k → ID k), deskew_done rises at t0 → BUILD for 20 cycles, done at t0+21, selector = identity; i_data chunk k = k → o_data chunk p = p one cycle later with o_valid matching i_valid.
- Reversed IDs (lane k → ID 19-k) → selector entry p = 19-p; i_data chunk k = 0xA00+k → o_data chunk p = 0xA00+19-p.
- Duplicate: lanes 3 and 7 both ID 5 → o_reorder_error=1 after 20 BUILD cycles, o_reorder_done=0, o_valid stays 0; a restart pulse then returns to IDLE, and a valid rebuild reaches DONE.
- Out-of-range: lane 12 ID = 25 (NB_ID=5) → error, no selector write for that lane.
- Enable gaps: i_enable toggled 1/0 during BUILD → done asserts after exactly 20 enabled cycles, selector correct, o_valid=0 in every disabled cycle.
- Deskew drop: i_deskew_done falls mid-BUILD (counter=8) and again in DONE → IDLE each time, selector = identity, o_reorder_done=0 next cycle; i_reset asserted in DONE → all outputs at reset values next edge.
